// File: rtl/tug_playfield_if.sv
// ============================================================================
// Module      : tug_playfield_if
// Description : Press inputs and playfield/score outputs of tug_playfield.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface tug_playfield_if #(
    parameter int NUM_LIGHTS = 9,
    parameter int SCORE_W    = 3
);
    logic                  L;
    logic                  R;
    logic                  new_game;
    logic [NUM_LIGHTS-1:0] lights;
    logic [SCORE_W-1:0]    score_l;
    logic [SCORE_W-1:0]    score_r;
    logic                  point_l;
    logic                  point_r;
    logic [1:0]            winner;
    logic                  game_over;

    modport master (
        output L, R, new_game,
        input  lights, score_l, score_r, point_l, point_r, winner, game_over
    );

    modport slave (
        input  L, R, new_game,
        output lights, score_l, score_r, point_l, point_r, winner, game_over
    );
endinterface

`default_nettype wire

// File: rtl/tug_playfield.sv
// ============================================================================
// Module      : tug_playfield
// Description : One-hot tug-of-war playfield with scoring and match end.
//               Optional serve gap after a point: TUG_PLAYFIELD_SERVE_DELAY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tug_playfield #(
    parameter int NUM_LIGHTS   = 9,
    parameter int SCORE_W      = 3,
    parameter int WIN_SCORE    = 7,
    parameter int SERVE_CYCLES = 4
) (
    input  logic            clk,
    input  logic            reset,
    tug_playfield_if.slave  bus
);

    localparam logic [NUM_LIGHTS-1:0] c_center =
        {{(NUM_LIGHTS-1){1'b0}}, 1'b1} << ((NUM_LIGHTS-1)/2);
    localparam logic [SCORE_W-1:0] c_win = SCORE_W'(WIN_SCORE);

    if ((NUM_LIGHTS < 3) || (NUM_LIGHTS % 2 == 0) || (WIN_SCORE < 1) ||
        (WIN_SCORE > (2**SCORE_W) - 1) || (SERVE_CYCLES < 1)) begin : g_param_check
        $error("tug_playfield: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        S_PLAY  = 2'd0,
`ifdef TUG_PLAYFIELD_SERVE_DELAY_EN
        S_SERVE = 2'd2,
`endif
        S_OVER  = 2'd1
    } state_t;

    state_t                r_state,     w_state_nxt;
    logic [NUM_LIGHTS-1:0] r_lights,    w_lights_nxt;
    logic [SCORE_W-1:0]    r_score_l,   w_score_l_nxt;
    logic [SCORE_W-1:0]    r_score_r,   w_score_r_nxt;
    logic                  r_point_l,   w_point_l_nxt;
    logic                  r_point_r,   w_point_r_nxt;
    logic [1:0]            r_winner,    w_winner_nxt;
    logic                  r_game_over, w_game_over_nxt;
    logic                  w_left, w_right, w_resume;

`ifdef TUG_PLAYFIELD_SERVE_DELAY_EN
    localparam int c_serve_w = $clog2(SERVE_CYCLES + 1);
    localparam logic [c_serve_w-1:0] c_serve_last = c_serve_w'(SERVE_CYCLES - 1);
    logic [c_serve_w-1:0] r_serve_cnt, w_serve_cnt_nxt;
`endif

    assign w_left  = bus.L & ~bus.R;
    assign w_right = bus.R & ~bus.L;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_PLAY;
            r_lights    <= c_center;
            r_score_l   <= '0;
            r_score_r   <= '0;
            r_point_l   <= 1'b0;
            r_point_r   <= 1'b0;
            r_winner    <= 2'b00;
            r_game_over <= 1'b0;
`ifdef TUG_PLAYFIELD_SERVE_DELAY_EN
            r_serve_cnt <= '0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_lights    <= w_lights_nxt;
            r_score_l   <= w_score_l_nxt;
            r_score_r   <= w_score_r_nxt;
            r_point_l   <= w_point_l_nxt;
            r_point_r   <= w_point_r_nxt;
            r_winner    <= w_winner_nxt;
            r_game_over <= w_game_over_nxt;
`ifdef TUG_PLAYFIELD_SERVE_DELAY_EN
            r_serve_cnt <= w_serve_cnt_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_lights_nxt    = r_lights;
        w_score_l_nxt   = r_score_l;
        w_score_r_nxt   = r_score_r;
        w_point_l_nxt   = 1'b0;
        w_point_r_nxt   = 1'b0;
        w_winner_nxt    = r_winner;
        w_game_over_nxt = r_game_over;
        w_resume        = 1'b0;
`ifdef TUG_PLAYFIELD_SERVE_DELAY_EN
        w_serve_cnt_nxt = r_serve_cnt;
`endif

        case (r_state)
            S_PLAY: begin
                if (w_left && r_lights[NUM_LIGHTS-1]) begin
                    w_score_l_nxt = r_score_l + SCORE_W'(1);
                    w_point_l_nxt = 1'b1;
                    if (w_score_l_nxt == c_win) begin
                        w_state_nxt     = S_OVER;
                        w_lights_nxt    = '0;
                        w_winner_nxt    = 2'b10;
                        w_game_over_nxt = 1'b1;
                    end else begin
                        w_resume = 1'b1;
                    end
                end else if (w_left) begin
                    w_lights_nxt = r_lights << 1;
                end else if (w_right && r_lights[0]) begin
                    w_score_r_nxt = r_score_r + SCORE_W'(1);
                    w_point_r_nxt = 1'b1;
                    if (w_score_r_nxt == c_win) begin
                        w_state_nxt     = S_OVER;
                        w_lights_nxt    = '0;
                        w_winner_nxt    = 2'b01;
                        w_game_over_nxt = 1'b1;
                    end else begin
                        w_resume = 1'b1;
                    end
                end else if (w_right) begin
                    w_lights_nxt = r_lights >> 1;
                end
            end
`ifdef TUG_PLAYFIELD_SERVE_DELAY_EN
            S_SERVE: begin
                if (r_serve_cnt == c_serve_last) begin
                    w_state_nxt  = S_PLAY;
                    w_lights_nxt = c_center;
                end else begin
                    w_serve_cnt_nxt = r_serve_cnt + c_serve_w'(1);
                end
            end
`endif
            S_OVER: begin
                if (bus.new_game) begin
                    w_state_nxt     = S_PLAY;
                    w_lights_nxt    = c_center;
                    w_score_l_nxt   = '0;
                    w_score_r_nxt   = '0;
                    w_winner_nxt    = 2'b00;
                    w_game_over_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt     = S_PLAY;
                w_lights_nxt    = c_center;
                w_score_l_nxt   = '0;
                w_score_r_nxt   = '0;
                w_winner_nxt    = 2'b00;
                w_game_over_nxt = 1'b0;
            end
        endcase

        // Non-winning point: either a blank serve gap or an immediate re-centre.
        if (w_resume) begin
`ifdef TUG_PLAYFIELD_SERVE_DELAY_EN
            w_state_nxt     = S_SERVE;
            w_lights_nxt    = '0;
            w_serve_cnt_nxt = '0;
`else
            w_lights_nxt    = c_center;
`endif
        end
    end

    assign bus.lights    = r_lights;
    assign bus.score_l   = r_score_l;
    assign bus.score_r   = r_score_r;
    assign bus.point_l   = r_point_l;
    assign bus.point_r   = r_point_r;
    assign bus.winner    = r_winner;
    assign bus.game_over = r_game_over;

endmodule

`default_nettype wire

// File: tb/tb_tug_playfield.sv
// ============================================================================
// Module      : tb_tug_playfield
// Description : Scoreboard bench for tug_playfield against a position/score model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tug_playfield;

    localparam int N   = 5;
    localparam int SW  = 3;
    localparam int WIN = 2;
    localparam int SC  = 3;
    localparam int C   = (N - 1) / 2;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    tug_playfield_if #(.NUM_LIGHTS(N), .SCORE_W(SW)) bus ();

    tug_playfield #(
        .NUM_LIGHTS  (N),
        .SCORE_W     (SW),
        .WIN_SCORE   (WIN),
        .SERVE_CYCLES(SC)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    typedef struct packed {
        logic [N-1:0]  lights;
        logic [SW-1:0] sl;
        logic [SW-1:0] sr;
        logic          pl;
        logic          pr;
        logic [1:0]    win;
        logic          go;
        logic [1:0]    mode;   // 0 play, 1 serve, 2 over
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;

    // Model: lit position as an index, scores as integers, mode as a small code.
    int         m_pos = C, m_sl = 0, m_sr = 0, m_mode = 0, m_serve_left = 0;
    logic [1:0] m_win = 2'b00;

    task automatic model_point(input bit left, output logic pl, output logic pr);
        pl = left;
        pr = !left;
        if (left) m_sl++; else m_sr++;
        if ((left ? m_sl : m_sr) == WIN) begin
            m_mode = 2;
            m_win  = left ? 2'b10 : 2'b01;
        end else begin
`ifdef TUG_PLAYFIELD_SERVE_DELAY_EN
            m_mode       = 1;
            m_serve_left = SC;
`else
            m_pos = C;
`endif
        end
    endtask

    task automatic model_step(input logic rs, input logic l, input logic r,
                              input logic ng, output exp_t e);
        logic pl, pr;
        pl = 1'b0;
        pr = 1'b0;
        if (rs) begin
            m_pos = C; m_sl = 0; m_sr = 0; m_mode = 0; m_win = 2'b00;
        end else if (m_mode == 0) begin
            if (l && !r) begin
                if (m_pos == N - 1) model_point(1'b1, pl, pr);
                else m_pos++;
            end else if (r && !l) begin
                if (m_pos == 0) model_point(1'b0, pl, pr);
                else m_pos--;
            end
        end else if (m_mode == 1) begin
            m_serve_left--;
            if (m_serve_left == 0) begin
                m_mode = 0;
                m_pos  = C;
            end
        end else if (ng) begin
            m_pos = C; m_sl = 0; m_sr = 0; m_mode = 0; m_win = 2'b00;
        end
        e.lights = (m_mode == 0) ? N'(1 << m_pos) : '0;
        e.sl     = SW'(m_sl);
        e.sr     = SW'(m_sr);
        e.pl     = pl;
        e.pr     = pr;
        e.win    = m_win;
        e.go     = (m_mode == 2);
        e.mode   = 2'(m_mode);
    endtask

    task automatic step(input logic rs, input logic l, input logic r, input logic ng);
        exp_t e;
        @(negedge clk);
        reset        = rs;
        bus.L        = l;
        bus.R        = r;
        bus.new_game = ng;
        model_step(rs, l, r, ng, e);
        q.push_back(e);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        tests++;
        if (act !== exp_v) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp_v, $time);
        end
    endtask

    // Monitor: outputs are registered, so compare shortly after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("lights",    32'(bus.lights),    32'(e.lights));
                chk("score_l",   32'(bus.score_l),   32'(e.sl));
                chk("score_r",   32'(bus.score_r),   32'(e.sr));
                chk("point_l",   32'(bus.point_l),   32'(e.pl));
                chk("point_r",   32'(bus.point_r),   32'(e.pr));
                chk("winner",    32'(bus.winner),    32'(e.win));
                chk("game_over", 32'(bus.game_over), 32'(e.go));
                chk("onehot",    32'($countones(bus.lights)), (e.mode == 2'd0) ? 32'd1 : 32'd0);
            end
        end
    end

    initial begin
        int k;
        bus.L        = 1'b0;
        bus.R        = 1'b0;
        bus.new_game = 1'b0;

        repeat (2) step(1, 0, 0, 0);
        repeat (3) step(0, 0, 0, 0);
        repeat (3) step(0, 1, 0, 0);
        step(0, 1, 1, 0);
        repeat (4) step(0, 0, 0, 0);
        repeat (3) step(0, 0, 1, 0);
        // Pulses during the serve gap must be ignored.
        step(0, 1, 0, 0);
        step(0, 0, 1, 1);
        repeat (2) step(0, 0, 0, 0);
        repeat (3) step(0, 0, 1, 0);
        step(0, 1, 0, 0);
        step(0, 0, 1, 0);
        step(0, 1, 1, 0);
        step(0, 0, 0, 1);
        repeat (2) step(0, 0, 0, 1);
        repeat (3) step(0, 1, 0, 0);
        repeat (4) step(0, 0, 0, 0);
        step(0, 0, 1, 0);
        step(1, 0, 0, 0);
        repeat (3) step(0, 1, 0, 0);
        repeat (4) step(0, 0, 0, 0);
        repeat (3) step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        step(1, 0, 0, 0);
        repeat (2) step(0, 0, 0, 0);

        for (int i = 0; i < 3000; i++) begin
            logic rs, l, r, ng;
            rs = ($urandom_range(0, 99) == 0);
            l  = ($urandom_range(0, 2) == 0);
            r  = ($urandom_range(0, 2) == 0);
            ng = ($urandom_range(0, 7) == 0);
            step(rs, l, r, ng);
        end

        k = 0;
        while (q.size() > 0 && k < 20) begin
            @(posedge clk);
            k++;
        end
        #3;
        if (q.size() > 0) begin
            fails++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
